// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-wide instruction queue between fetch and dual-issue decode
// Optional FETCH_QUEUE_BYPASS_EN: pass a pushed pair straight to decode when the queue is empty.
module fetch_queue #(
   parameter int DEPTH = 8,
   parameter int PTRW  = 3
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            validf,
   input  logic [31:0]     instrf,
   input  logic [31:0]     instrf2,
   input  logic [31:0]     pcf,
   input  logic            flushd,
   input  logic [1:0]      consume,
   output logic            stallf,
   output logic [31:0]     instrd,
   output logic [31:0]     pcd,
   output logic            validd,
   output logic [31:0]     instrd2,
   output logic [31:0]     pcd2,
   output logic            validd2,
   output logic [PTRW:0]   count
);
   localparam logic [PTRW:0] STALL_AT = (PTRW+1)'(DEPTH - 1);
   localparam logic [PTRW:0] ONE      = (PTRW+1)'(1);

   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     pc_mem    [DEPTH];
   logic [PTRW-1:0] head, tail;
   logic [PTRW-1:0] head_p1, tail_p1;
   logic [PTRW:0]   count_q, count_next, ce_ext;
   logic [31:0]     pcf_p4;
   logic [1:0]      consume_eff, pop_n, wr_n;
   logic            push, bypass;
   logic            wr_pair, wr_second_only;

   assign head_p1     = head + PTRW'(1);
   assign tail_p1     = tail + PTRW'(1);
   assign pcf_p4      = pcf + 32'd4;
   assign count       = count_q;

   // Uses pre-pop occupancy only, so a full queue never overflows on push+pop.
   assign stallf      = count_q >= STALL_AT;
   assign push        = validf & ~stallf & ~flushd;
   assign consume_eff = (consume == 2'd3) ? 2'd2 : consume;
   assign ce_ext      = (PTRW+1)'(consume_eff);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = push & (count_q == '0);
`else
   assign bypass = 1'b0;
`endif

   always_comb begin
      pop_n          = 2'd0;
      wr_n           = 2'd0;
      wr_pair        = 1'b0;
      wr_second_only = 1'b0;
      if (bypass) begin
         // Decode eats from the front of the incoming pair; only leftovers are stored.
         wr_n           = 2'd2 - consume_eff;
         wr_pair        = (consume_eff == 2'd0);
         wr_second_only = (consume_eff == 2'd1);
      end else begin
         pop_n = (count_q < ce_ext) ? count_q[1:0] : consume_eff;
         if (push) begin
            wr_n    = 2'd2;
            wr_pair = 1'b1;
         end
      end
      count_next = count_q + (PTRW+1)'(wr_n) - (PTRW+1)'(pop_n);
   end

   always_ff @(posedge clk) begin
      if (reset || flushd) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         head    <= head + PTRW'(pop_n);
         tail    <= tail + PTRW'(wr_n);
         count_q <= count_next;
      end
   end

   // Storage is not reset; the valid-gated output mux hides stale contents.
   always_ff @(posedge clk) begin
      if (wr_pair) begin
         instr_mem[tail]    <= instrf;
         pc_mem[tail]       <= pcf;
         instr_mem[tail_p1] <= instrf2;
         pc_mem[tail_p1]    <= pcf_p4;
      end else if (wr_second_only) begin
         instr_mem[tail]    <= instrf2;
         pc_mem[tail]       <= pcf_p4;
      end
   end

   always_comb begin
      validd  = (count_q >= ONE);
      validd2 = (count_q > ONE);
      instrd  = validd  ? instr_mem[head]    : 32'h0;
      pcd     = validd  ? pc_mem[head]       : 32'h0;
      instrd2 = validd2 ? instr_mem[head_p1] : 32'h0;
      pcd2    = validd2 ? pc_mem[head_p1]    : 32'h0;
      if (bypass) begin
         validd  = 1'b1;
         validd2 = 1'b1;
         instrd  = instrf;
         pcd     = pcf;
         instrd2 = instrf2;
         pcd2    = pcf_p4;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
   localparam int DEPTH = 8;
   localparam int PTRW  = 3;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          validf = 1'b0;
   logic [31:0]   instrf = '0;
   logic [31:0]   instrf2 = '0;
   logic [31:0]   pcf = '0;
   logic          flushd = 1'b0;
   logic [1:0]    consume = '0;
   logic          stallf;
   logic [31:0]   instrd, pcd, instrd2, pcd2;
   logic          validd, validd2;
   logic [PTRW:0] count;

   int   n_cmp = 0;
   int   n_fail = 0;
   bit   cmp_en = 1'b0;
   ent_t mq[$];
   ent_t ea, eb;
   int   m_ce, m_n;
   bit   m_push;
   logic [31:0] e_instrd, e_pcd, e_instrd2, e_pcd2;
   logic        e_validd, e_validd2, e_stallf;
   int          e_count;
   logic [31:0] nxt_pc, prev_pcd;

   fetch_queue #(.DEPTH(DEPTH), .PTRW(PTRW)) dut (
      .clk(clk), .reset(reset), .validf(validf), .instrf(instrf), .instrf2(instrf2),
      .pcf(pcf), .flushd(flushd), .consume(consume), .stallf(stallf),
      .instrd(instrd), .pcd(pcd), .validd(validd), .instrd2(instrd2),
      .pcd2(pcd2), .validd2(validd2), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [31:0] pc);
      return 32'hA000_0000 ^ pc;
   endfunction

   // Reference: FIFO of entries; room for a pair judged on occupancy before this cycle's pops.
   always @(posedge clk) begin
      if (reset || flushd) begin
         mq.delete();
      end else begin
         m_ce   = (consume == 2'd3) ? 2 : int'(consume);
         m_push = validf && ((DEPTH - mq.size()) >= 2);
         ea.instr = instrf;  ea.pc = pcf;
         eb.instr = instrf2; eb.pc = pcf + 32'd4;
`ifdef FETCH_QUEUE_BYPASS_EN
         if (m_push && mq.size() == 0) begin
            if (m_ce == 0) mq.push_back(ea);
            if (m_ce <= 1) mq.push_back(eb);
         end else
`endif
         begin
            m_n = (m_ce < mq.size()) ? m_ce : mq.size();
            for (int k = 0; k < m_n; k++) void'(mq.pop_front());
            if (m_push) begin
               mq.push_back(ea);
               mq.push_back(eb);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         e_count   = mq.size();
         e_stallf  = (DEPTH - mq.size()) < 2;
         e_validd  = mq.size() >= 1;
         e_validd2 = mq.size() >= 2;
         e_instrd  = e_validd  ? mq[0].instr : 32'h0;
         e_pcd     = e_validd  ? mq[0].pc    : 32'h0;
         e_instrd2 = e_validd2 ? mq[1].instr : 32'h0;
         e_pcd2    = e_validd2 ? mq[1].pc    : 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
         if (mq.size() == 0 && validf && !flushd) begin
            e_validd = 1'b1; e_validd2 = 1'b1;
            e_instrd = instrf; e_pcd = pcf; e_instrd2 = instrf2; e_pcd2 = pcf + 32'd4;
         end
`endif
         chk("m_count",   32'(count),   32'(e_count));
         chk("m_stallf",  32'(stallf),  32'(e_stallf));
         chk("m_validd",  32'(validd),  32'(e_validd));
         chk("m_validd2", 32'(validd2), 32'(e_validd2));
         chk("m_instrd",  instrd,  e_instrd);
         chk("m_pcd",     pcd,     e_pcd);
         chk("m_instrd2", instrd2, e_instrd2);
         chk("m_pcd2",    pcd2,    e_pcd2);
      end
   end

   task automatic cyc(input bit v, input logic [31:0] i1, input logic [31:0] i2,
                      input logic [31:0] pc, input logic [1:0] cons, input bit fl, input bit rst);
      validf = v; instrf = i1; instrf2 = i2; pcf = pc;
      consume = cons; flushd = fl; reset = rst;
      @(posedge clk);
      #1;
      validf = 1'b0; consume = 2'd0; flushd = 1'b0; reset = 1'b0;
      #1;
   endtask

   task automatic push_pair(input logic [31:0] pc, input logic [1:0] cons);
      cyc(1'b1, mk(pc), mk(pc + 32'd4), pc, cons, 1'b0, 1'b0);
   endtask

   initial begin
      cyc(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b1);
      cmp_en = 1'b1;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_stallf", 32'(stallf), 32'd0);
      chk("rst_validd", 32'(validd), 32'd0);
      chk("rst_instrd", instrd, 32'h0);

      cyc(1'b1, 32'h20080005, 32'h20090007, 32'h0, 2'd0, 1'b0, 1'b0);
      chk("p1_count", 32'(count), 32'd2);
      chk("p1_validd2", 32'(validd2), 32'd1);
      chk("p1_instrd", instrd, 32'h20080005);
      chk("p1_instrd2", instrd2, 32'h20090007);
      chk("p1_pcd2", pcd2, 32'h4);
      chk("p1_stallf", 32'(stallf), 32'd0);

      push_pair(32'd8, 2'd0);
      push_pair(32'd16, 2'd0);
      push_pair(32'd24, 2'd0);
      chk("full_count", 32'(count), 32'd8);
      chk("full_stallf", 32'(stallf), 32'd1);
      push_pair(32'd32, 2'd0);
      chk("blocked_count", 32'(count), 32'd8);
      chk("blocked_pcd", pcd, 32'h0);
      push_pair(32'd32, 2'd2);
      chk("pop2_full_count", 32'(count), 32'd6);
      chk("pop2_full_pcd", pcd, 32'd8);

      cyc(1'b0, '0, '0, '0, 2'd2, 1'b0, 1'b0);
      cyc(1'b0, '0, '0, '0, 2'd1, 1'b0, 1'b0);
      chk("c3_count", 32'(count), 32'd3);
      chk("c3_stallf", 32'(stallf), 32'd0);
      push_pair(32'd32, 2'd1);
      chk("pp_count", 32'(count), 32'd4);
      chk("pp_pcd", pcd, 32'd24);
      chk("pp_pcd2", pcd2, 32'd28);

      cyc(1'b0, '0, '0, '0, 2'd3, 1'b0, 1'b0);
      chk("c3as2_count", 32'(count), 32'd2);
      chk("c3as2_pcd", pcd, 32'd32);

      nxt_pc = 32'd40;
      for (int k = 0; k < DEPTH && !stallf; k++) begin
         push_pair(nxt_pc, 2'd0);
         nxt_pc = nxt_pc + 32'd8;
      end
      chk("wrap_fill", 32'(count), 32'd8);
      for (int k = 0; k < 20; k++) begin
         prev_pcd = pcd;
         if (!stallf) begin
            push_pair(nxt_pc, 2'd1);
            nxt_pc = nxt_pc + 32'd8;
         end else begin
            cyc(1'b0, '0, '0, '0, 2'd1, 1'b0, 1'b0);
         end
         chk("wrap_seq", pcd, prev_pcd + 32'd4);
      end

      cyc(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b1);
      push_pair(32'h100, 2'd0);
      push_pair(32'h108, 2'd0);
      push_pair(32'h110, 2'd0);
      chk("pre_flush_count", 32'(count), 32'd6);
      cyc(1'b1, mk(32'h118), mk(32'h11c), 32'h118, 2'd2, 1'b1, 1'b0);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_validd", 32'(validd), 32'd0);
      chk("flush_instrd", instrd, 32'h0);
      chk("flush_stallf", 32'(stallf), 32'd0);
      cyc(1'b1, mk(32'h118), mk(32'h11c), 32'h118, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, mk(32'h118), mk(32'h11c), 32'h118, 2'd0, 1'b1, 1'b0);
      chk("flush_hold_count", 32'(count), 32'd0);

      push_pair(32'h200, 2'd0);
      push_pair(32'h208, 2'd0);
      push_pair(32'h210, 2'd1);
      chk("c5_count", 32'(count), 32'd5);
      chk("c5_pcd", pcd, 32'h204);
      cyc(1'b1, mk(32'h218), mk(32'h21c), 32'h218, 2'd2, 1'b0, 1'b1);
      chk("midrst_count", 32'(count), 32'd0);
      chk("midrst_pcd", pcd, 32'h0);
      chk("midrst_pcd2", pcd2, 32'h0);
      chk("midrst_instrd2", instrd2, 32'h0);

`ifdef FETCH_QUEUE_BYPASS_EN
      validf = 1'b1; instrf = 32'h1111_0001; instrf2 = 32'h2222_0002; pcf = 32'h300; consume = 2'd2;
      #1;
      chk("byp_instrd", instrd, 32'h1111_0001);
      chk("byp_pcd2", pcd2, 32'h304);
      chk("byp_validd2", 32'(validd2), 32'd1);
      @(posedge clk);
      #1;
      validf = 1'b0; consume = 2'd0;
      #1;
      chk("byp_count", 32'(count), 32'd0);
      cyc(1'b1, 32'h3333_0003, 32'h4444_0004, 32'h400, 2'd1, 1'b0, 1'b0);
      chk("byp1_count", 32'(count), 32'd1);
      chk("byp1_pcd", pcd, 32'h404);
      chk("byp1_instrd", instrd, 32'h4444_0004);
`endif

      cyc(1'b0, '0, '0, '0, 2'd0, 1'b0, 1'b0);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
